// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: lets two requesters share one combinational ALU.
// Each operation goes through the states IDLE (accept), EXEC (the ALU settles on the
// registered operands) and RESP (the result is held until the owner consumes it).
// Optional build macro: ALU_ARB_FIXED_PRIO_EN. When it is defined, req0 always wins a
// tie and the round-robin pointer is removed.
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int TYPE_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req0_op1,
    input  logic [DATA_W-1:0] req0_op2,
    input  logic [TYPE_W-1:0] req0_type,
    input  logic [DATA_W-1:0] req1_op1,
    input  logic [DATA_W-1:0] req1_op2,
    input  logic [TYPE_W-1:0] req1_type,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic [TYPE_W-1:0] alu_type,
    input  logic [DATA_W-1:0] alu_out,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic [DATA_W-1:0] alu_op1_q, alu_op1_d;
    logic [DATA_W-1:0] alu_op2_q, alu_op2_d;
    logic [TYPE_W-1:0] alu_type_q, alu_type_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic              grant1;
`ifndef ALU_ARB_FIXED_PRIO_EN
    // rr_q = 0 favours req0 on a tie, rr_q = 1 favours req1
    logic              rr_q, rr_d;
`endif

    // Pick the winner: a lone requester always wins; a tie goes to the favoured one
    always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        grant1 = req_valid[1] & ~req_valid[0];
`else
        grant1 = req_valid[1] & (~req_valid[0] | rr_q);
`endif
    end

    // Next-state, operand capture and result capture for the accept/exec/respond cycle
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        alu_op1_d   = alu_op1_q;
        alu_op2_d   = alu_op2_q;
        alu_type_d  = alu_type_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        req_ready   = 2'b00;
`ifndef ALU_ARB_FIXED_PRIO_EN
        rr_d        = rr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    req_ready  = grant1 ? 2'b10 : 2'b01;
                    owner_d    = grant1;
                    alu_op1_d  = grant1 ? req1_op1  : req0_op1;
                    alu_op2_d  = grant1 ? req1_op2  : req0_op2;
                    alu_type_d = grant1 ? req1_type : req0_type;
`ifndef ALU_ARB_FIXED_PRIO_EN
                    rr_d       = ~grant1;
`endif
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_data_d  = alu_out;
                rsp_valid_d = owner_q ? 2'b10 : 2'b01;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready[owner_q]) begin
                    rsp_valid_d = 2'b00;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any operation in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            alu_op1_q   <= '0;
            alu_op2_q   <= '0;
            alu_type_q  <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 2'b00;
`ifndef ALU_ARB_FIXED_PRIO_EN
            rr_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            alu_op1_q   <= alu_op1_d;
            alu_op2_q   <= alu_op2_d;
            alu_type_q  <= alu_type_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
            rr_q        <= rr_d;
`endif
        end
    end

    assign alu_op1   = alu_op1_q;
    assign alu_op2   = alu_op2_q;
    assign alu_type  = alu_type_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_valid = rsp_valid_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: vector table of single operations, hand-written
// contention / backpressure / wrong-owner / reset sequences, and a randomized phase
// compared against a transaction-level model (winner choice plus ALU function).
module tb_alu_share_arbiter;

    localparam logic [3:0] T_ADD = 4'd0;
    localparam logic [3:0] T_SUB = 4'd1;
    localparam logic [3:0] T_XOR = 4'd2;
    localparam logic [3:0] T_AND = 4'd3;
    localparam logic [3:0] T_OR  = 4'd4;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
    logic [3:0]  req0_type, req1_type;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_data;
    logic [31:0] alu_op1, alu_op2;
    logic [3:0]  alu_type;
    logic [31:0] alu_out;
    logic        busy;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          who;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  typ;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [8];

    alu_share_arbiter #(.DATA_W(32), .TYPE_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req0_op1  (req0_op1),
        .req0_op2  (req0_op2),
        .req0_type (req0_type),
        .req1_op1  (req1_op1),
        .req1_op2  (req1_op2),
        .req1_type (req1_type),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .alu_op1   (alu_op1),
        .alu_op2   (alu_op2),
        .alu_type  (alu_type),
        .alu_out   (alu_out),
        .busy      (busy)
    );

    // Stand-in for the shared ALU; undefined types give 0
    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] t);
        case (t)
            T_ADD:   return a + b;
            T_SUB:   return a - b;
            T_XOR:   return a ^ b;
            T_AND:   return a & b;
            T_OR:    return a | b;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_out = alu_fn(alu_op1, alu_op2, alu_type);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester-side protocol check: a valid that has not seen ready must stay up
    logic [1:0] hold_q = 2'b00;
    always @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (hold_q[i] && !req_valid[i])
                    $error("[TB] requester %0d dropped valid before ready", i);
            end
            hold_q <= req_valid & ~req_ready;
        end else begin
            hold_q <= 2'b00;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] bit_of(input int who);
        return (who == 1) ? 2'b10 : 2'b01;
    endfunction

    // Wait (bounded) until the arbiter offers ready to someone
    task automatic waitReady();
        int n = 0;
        #1;
        while (req_ready == 2'b00 && n < 20) begin
            step();
            #1;
            n++;
        end
        if (n >= 20) begin
            tests++;
            fails++;
            $display("[TB] FAIL ready_timeout: got req_ready=%b, expected a grant", req_ready);
        end
    endtask

    task automatic doReset();
        rst_n     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        step();
        rst_n = 1'b1;
    endtask

    // One lone-requester operation from accept to completion, checked against its vector
    task automatic applyStimulus(input vec_t v);
        logic [1:0] b;
        b = bit_of(v.who);
        if (v.who == 1) begin
            req1_op1 = v.op1; req1_op2 = v.op2; req1_type = v.typ;
        end else begin
            req0_op1 = v.op1; req0_op2 = v.op2; req0_type = v.typ;
        end
        req_valid = b;
        #1;
        checkOutput("vec_grant", {30'd0, req_ready}, {30'd0, b});
        step();
        req_valid = 2'b00;
        checkOutput("vec_alu_op1", alu_op1, v.op1);
        checkOutput("vec_alu_op2", alu_op2, v.op2);
        checkOutput("vec_alu_type", {28'd0, alu_type}, {28'd0, v.typ});
        checkOutput("vec_rsp_early", {30'd0, rsp_valid}, 32'd0);
        step();
        checkOutput("vec_rsp_valid", {30'd0, rsp_valid}, {30'd0, b});
        checkOutput("vec_rsp_data", rsp_data, v.exp);
        rsp_ready = b;
        step();
        rsp_ready = 2'b00;
        checkOutput("vec_done_valid", {30'd0, rsp_valid}, 32'd0);
        checkOutput("vec_done_busy", {31'd0, busy}, 32'd0);
        checkOutput("vec_alu_keep", alu_op1, v.op1);
    endtask

    initial begin
        logic [1:0]  exp_grant [3];
        logic [31:0] exp_data  [3];
        logic [31:0] held;
        logic [31:0] p_op1 [2];
        logic [31:0] p_op2 [2];
        logic [3:0]  p_typ [2];
        logic [1:0]  pend;
        int          fav;
        int          w;
        int          d;

        vecs[0] = '{0, 32'd5,         32'd7,         T_ADD, 32'd12};
        vecs[1] = '{1, 32'd10,        32'd3,         T_SUB, 32'd7};
        vecs[2] = '{0, 32'h0000_00F0, 32'h0000_00FF, T_XOR, 32'h0000_000F};
        vecs[3] = '{1, 32'hFF00_FF00, 32'h0F0F_0F0F, T_AND, 32'h0F00_0F00};
        vecs[4] = '{0, 32'h0000_00F0, 32'h0000_000F, T_OR,  32'h0000_00FF};
        vecs[5] = '{1, 32'hFFFF_FFFF, 32'd1,         T_ADD, 32'd0};
        vecs[6] = '{0, 32'd1,         32'd2,         4'hD,  32'd0};
        vecs[7] = '{0, 32'd3,         32'd5,         T_SUB, 32'hFFFF_FFFE};

        rst_n = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        req0_op1 = 32'd0; req0_op2 = 32'd0; req0_type = 4'd0;
        req1_op1 = 32'd0; req1_op2 = 32'd0; req1_type = 4'd0;
        step();
        step();

        // Reset state
        checkOutput("rst_req_ready", {30'd0, req_ready}, 32'd0);
        checkOutput("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        checkOutput("rst_rsp_data", rsp_data, 32'd0);
        checkOutput("rst_alu_op1", alu_op1, 32'd0);
        checkOutput("rst_alu_op2", alu_op2, 32'd0);
        checkOutput("rst_alu_type", {28'd0, alu_type}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;

        // Contention from reset, both requesters held valid
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_grant[0] = 2'b01; exp_grant[1] = 2'b01; exp_grant[2] = 2'b01;
        exp_data[0]  = 32'd7; exp_data[1]  = 32'd7; exp_data[2]  = 32'd7;
`else
        exp_grant[0] = 2'b01; exp_grant[1] = 2'b10; exp_grant[2] = 2'b01;
        exp_data[0]  = 32'd7; exp_data[1]  = 32'h0F; exp_data[2]  = 32'd7;
`endif
        req0_op1 = 32'd10;   req0_op2 = 32'd3;    req0_type = T_SUB;
        req1_op1 = 32'h0F0;  req1_op2 = 32'h0FF;  req1_type = T_XOR;
        req_valid = 2'b11;
        for (int k = 0; k < 3; k++) begin
            waitReady();
            checkOutput("cont_grant", {30'd0, req_ready}, {30'd0, exp_grant[k]});
            step();
            checkOutput("cont_alu_op1", alu_op1, (exp_grant[k] == 2'b10) ? 32'h0F0 : 32'd10);
            checkOutput("cont_busy", {31'd0, busy}, 32'd1);
            step();
            checkOutput("cont_rsp_valid", {30'd0, rsp_valid}, {30'd0, exp_grant[k]});
            checkOutput("cont_rsp_data", rsp_data, exp_data[k]);
            rsp_ready = 2'b11;
            step();
            rsp_ready = 2'b00;
        end
        doReset();

        // Vector table of single operations
        for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

        // Backpressure on a req1 op while req0 waits
        req1_op1 = 32'd100; req1_op2 = 32'd23; req1_type = T_SUB;
        req_valid = 2'b10;
        step();
        req_valid = 2'b00;
        step();
        held = rsp_data;
        checkOutput("bp_data", held, 32'd77);
        req0_op1 = 32'd40; req0_op2 = 32'd2; req0_type = T_ADD;
        req_valid = 2'b01;
        for (int c = 0; c < 4; c++) begin
            #1;
            checkOutput("bp_req_ready", {30'd0, req_ready}, 32'd0);
            checkOutput("bp_rsp_valid", {30'd0, rsp_valid}, 32'b10);
            checkOutput("bp_rsp_stable", rsp_data, 32'd77);
            step();
        end
        rsp_ready = 2'b10;
        step();
        rsp_ready = 2'b00;
        checkOutput("bp_release", {30'd0, rsp_valid}, 32'd0);
        #1;
        checkOutput("bp_next_grant", {30'd0, req_ready}, 32'b01);

        // Wrong-owner ready while req0 owns the result
        step();
        req_valid = 2'b00;
        step();
        rsp_ready = 2'b10;
        for (int c = 0; c < 3; c++) begin
            step();
            checkOutput("wo_rsp_valid", {30'd0, rsp_valid}, 32'b01);
            checkOutput("wo_rsp_data", rsp_data, 32'd42);
            checkOutput("wo_busy", {31'd0, busy}, 32'd1);
        end
        rsp_ready = 2'b01;
        step();
        rsp_ready = 2'b00;
        checkOutput("wo_done", {30'd0, rsp_valid}, 32'd0);

        // Reset during EXEC drops the operation
        req1_op1 = 32'd9; req1_op2 = 32'd9; req1_type = T_ADD;
        req_valid = 2'b10;
        step();
        req_valid = 2'b00;
        checkOutput("rm_in_exec", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        step();
        checkOutput("rm_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        checkOutput("rm_rsp_data", rsp_data, 32'd0);
        checkOutput("rm_alu_op1", alu_op1, 32'd0);
        checkOutput("rm_alu_type", {28'd0, alu_type}, 32'd0);
        checkOutput("rm_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            checkOutput("rm_no_rsp", {30'd0, rsp_valid}, 32'd0);
        end
        req_valid = 2'b11;
        #1;
        checkOutput("rm_rr_reset", {30'd0, req_ready}, 32'b01);
        doReset();

        // Randomized phase against the transaction-level model
        fav  = 0;
        pend = 2'b00;
        for (int it = 0; it < 60; it++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i]  = 1'b1;
                    p_op1[i] = $urandom;
                    p_op2[i] = $urandom;
                    p_typ[i] = 4'($urandom_range(0, 7));
                end
            end
            if (pend == 2'b00) begin
                pend[0]  = 1'b1;
                p_op1[0] = $urandom;
                p_op2[0] = $urandom;
                p_typ[0] = 4'($urandom_range(0, 7));
            end
            req0_op1 = p_op1[0]; req0_op2 = p_op2[0]; req0_type = p_typ[0];
            req1_op1 = p_op1[1]; req1_op2 = p_op2[1]; req1_type = p_typ[1];
            req_valid = pend;
            if (pend == 2'b11) w = fav;
            else w = pend[1] ? 1 : 0;
            waitReady();
            checkOutput("rnd_grant", {30'd0, req_ready}, {30'd0, bit_of(w)});
            step();
            pend[w]   = 1'b0;
            req_valid = pend;
`ifdef ALU_ARB_FIXED_PRIO_EN
            fav = 0;
`else
            fav = 1 - w;
`endif
            checkOutput("rnd_alu_type", {28'd0, alu_type}, {28'd0, p_typ[w]});
            step();
            checkOutput("rnd_rsp_valid", {30'd0, rsp_valid}, {30'd0, bit_of(w)});
            checkOutput("rnd_rsp_data", rsp_data, alu_fn(p_op1[w], p_op2[w], p_typ[w]));
            d = $urandom_range(0, 3);
            for (int c = 0; c < d; c++) begin
                rsp_ready = bit_of(1 - w);
                step();
                checkOutput("rnd_hold", {30'd0, rsp_valid}, {30'd0, bit_of(w)});
            end
            rsp_ready = bit_of(w);
            step();
            rsp_ready = 2'b00;
            checkOutput("rnd_done", {30'd0, rsp_valid}, 32'd0);
        end
        doReset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
